// File: rtl/mdm_pkg.sv
// Shared types and helpers for the MDM message path: FSM state encoding and
// a width helper that never returns zero.
package mdm_pkg;

  typedef enum logic {ST_IDLE, ST_XFER} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority selector: picks the first requester above last_i, wrapping
// modulo NUM_REQ, and reports it both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      pick_idx_o
);

  logic found;

  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    // last_i itself is searched last, so a lone requester can win again
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_i[(int'(last_i) + i) % NUM_REQ]) begin
        found                                       = 1'b1;
        pick_o[(int'(last_i) + i) % NUM_REQ]        = 1'b1;
        pick_idx_o                                  = IW'((int'(last_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream byte sink between NUM_REQ sources;
// a grant lasts one packet, MAX_BURST beats, or until the owner idles too long.
module uart_tx_arbiter
  import mdm_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]   s_tvalid,
  input  logic [NUM_REQ-1:0]   s_tlast,
  output logic [NUM_REQ-1:0]   s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout
);

  localparam int IW = clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]        idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               in_xfer, own_vld, own_last, beat;
  logic [7:0]         own_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i      (s_tvalid),
    .last_i     (last_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx)
  );

  assign in_xfer  = (state_q == ST_XFER);
  assign own_vld  = s_tvalid[gidx_q];
  assign own_last = s_tlast[gidx_q];
  assign own_data = s_tdata[{gidx_q, 3'b000} +: 8];

  assign m_tvalid = in_xfer & own_vld;
  assign m_tdata  = in_xfer ? own_data : 8'h00;
  assign s_tready = in_xfer ? (grant_q & {NUM_REQ{m_tready}}) : '0;
  assign grant    = grant_q;
  assign timeout  = timeout_q;
  assign beat     = m_tvalid & m_tready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|s_tvalid) begin
          grant_d    = pick;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          idle_cnt_d = '0;
          // tlast and the burst cap on the same beat collapse into one release
          if (own_last || (beat_cnt_q + 8'd1 == 8'(MAX_BURST))) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = gidx_q;
          end
        end else if (own_vld) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == 16'(IDLE_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          grant_d   = '0;
          last_d    = gidx_q;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 4-byte burst cap and 8-cycle idle timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready, grant;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .grant    (grant),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic zero_inputs;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    zero_inputs();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    zero_inputs();
    nxt();
    nxt();
    smp();
    checks++;
    if ({grant, s_tready, m_tvalid, timeout, m_tdata} !== 18'd0) begin
      errors++;
      $display("FAIL reset_hold: got grant=%b rdy=%b vld=%b to=%b data=%h want all zero",
               grant, s_tready, m_tvalid, timeout, m_tdata);
    end
    nxt();
    rst = 1'b0;
    smp();
    checks++;
    if ({grant, s_tready, m_tvalid, timeout, m_tdata} !== 18'd0) begin
      errors++;
      $display("FAIL reset_release: got grant=%b rdy=%b vld=%b to=%b want all zero",
               grant, s_tready, m_tvalid, timeout);
    end
  endtask

  task automatic test_single;
    do_reset();
    s_tvalid = 4'b0010;
    s_tdata[15:8] = 8'h55;
    smp();
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_c0: got grant=%b vld=%b want 0000/0", grant, m_tvalid);
    end
    nxt();
    smp();
    checks++;
    if (grant !== 4'b0010 || m_tdata !== 8'h55 || m_tvalid !== 1'b1 || s_tready !== 4'b0010) begin
      errors++;
      $display("FAIL single_b1: got grant=%b data=%h vld=%b rdy=%b want 0010/55/1/0010",
               grant, m_tdata, m_tvalid, s_tready);
    end
    nxt();
    s_tdata[15:8] = 8'hAA;
    smp();
    checks++;
    if (grant !== 4'b0010 || m_tdata !== 8'hAA) begin
      errors++;
      $display("FAIL single_b2: got grant=%b data=%h want 0010/aa", grant, m_tdata);
    end
    nxt();
    s_tdata[15:8] = 8'h0F;
    s_tlast = 4'b0010;
    smp();
    checks++;
    if (grant !== 4'b0010 || m_tdata !== 8'h0F) begin
      errors++;
      $display("FAIL single_b3: got grant=%b data=%h want 0010/0f", grant, m_tdata);
    end
    nxt();
    zero_inputs();
    smp();
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got grant=%b vld=%b want 0000/0", grant, m_tvalid);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    s_tdata  = 32'hA3A2A1A0;
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << (i % 4);
      ed = 8'hA0 + 8'(i % 4);
      nxt();
      smp();
      checks++;
      if (grant !== eg || m_tdata !== ed) begin
        errors++;
        $display("FAIL fair_grant%0d: got grant=%b data=%h want %b/%h", i, grant, m_tdata, eg, ed);
      end
      nxt();
      smp();
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL fair_bubble%0d: got grant=%b want 0000", i, grant);
      end
    end
    zero_inputs();
  endtask

  task automatic test_burst_cap;
    logic [13:0] tbl;
    int n;
    tbl = 14'b01101111011110;
    do_reset();
    n = 1;
    for (int c = 0; c < 14; c++) begin
      s_tvalid[2] = (n <= 10);
      s_tlast[2]  = (n == 10);
      s_tdata[23:16] = 8'h10 + 8'(n);
      smp();
      checks++;
      if (grant !== (tbl[c] ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL burst_grant_c%0d: got %b want %b", c, grant, tbl[c] ? 4'b0100 : 4'b0000);
      end
      if (tbl[c]) begin
        checks++;
        if (m_tdata !== 8'h10 + 8'(n) || s_tready !== 4'b0100) begin
          errors++;
          $display("FAIL burst_data_c%0d: got data=%h rdy=%b want %h/0100",
                   c, m_tdata, s_tready, 8'h10 + 8'(n));
        end
        n++;
      end
      nxt();
    end
    zero_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    s_tvalid = 4'b0010;
    s_tdata[15:8] = 8'h31;
    nxt();
    m_tready = 1'b1;
    smp();
    checks++;
    if (s_tready !== 4'b0010 || m_tdata !== 8'h31) begin
      errors++;
      $display("FAIL bp_b1: got rdy=%b data=%h want 0010/31", s_tready, m_tdata);
    end
    nxt();
    s_tdata[15:8] = 8'h32;
    s_tlast = 4'b0010;
    m_tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      smp();
      checks++;
      if (s_tready !== 4'b0000 || m_tvalid !== 1'b1 || m_tdata !== 8'h32 || grant !== 4'b0010) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy=%b vld=%b data=%h grant=%b want 0000/1/32/0010",
                 k, s_tready, m_tvalid, m_tdata, grant);
      end
      nxt();
    end
    m_tready = 1'b1;
    smp();
    checks++;
    if (s_tready !== 4'b0010 || m_tdata !== 8'h32) begin
      errors++;
      $display("FAIL bp_b2: got rdy=%b data=%h want 0010/32", s_tready, m_tdata);
    end
    nxt();
    zero_inputs();
    smp();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL bp_end: got grant=%b want 0000", grant);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    s_tvalid = 4'b1001;
    s_tdata[7:0]   = 8'h77;
    s_tdata[31:24] = 8'hD3;
    nxt();
    smp();
    checks++;
    if (grant !== 4'b0001 || m_tdata !== 8'h77) begin
      errors++;
      $display("FAIL to_beat: got grant=%b data=%h want 0001/77", grant, m_tdata);
    end
    nxt();
    s_tvalid = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      smp();
      checks++;
      if (grant !== 4'b0001 || timeout !== 1'b0 || m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d: got grant=%b to=%b vld=%b want 0001/0/0", k, grant, timeout, m_tvalid);
      end
      nxt();
    end
    smp();
    checks++;
    if (timeout !== 1'b1 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL to_pulse: got to=%b grant=%b want 1/0000", timeout, grant);
    end
    nxt();
    smp();
    checks++;
    if (grant !== 4'b1000 || timeout !== 1'b0 || m_tdata !== 8'hD3) begin
      errors++;
      $display("FAIL to_next: got grant=%b to=%b data=%h want 1000/0/d3", grant, timeout, m_tdata);
    end
    zero_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    s_tvalid = 4'b0010;
    s_tdata[15:8] = 8'h61;
    nxt();
    nxt();
    s_tdata[15:8] = 8'h62;
    smp();
    checks++;
    if (grant !== 4'b0010 || m_tdata !== 8'h62) begin
      errors++;
      $display("FAIL rm_pre: got grant=%b data=%h want 0010/62", grant, m_tdata);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({grant, s_tready, m_tvalid, timeout, m_tdata} !== 18'd0) begin
      errors++;
      $display("FAIL rm_async: got grant=%b rdy=%b vld=%b to=%b want all zero",
               grant, s_tready, m_tvalid, timeout);
    end
    s_tvalid = 4'b0011;
    s_tdata[7:0] = 8'h40;
    nxt();
    nxt();
    rst = 1'b0;
    smp();
    checks++;
    if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rm_release: got grant=%b vld=%b want 0000/0", grant, m_tvalid);
    end
    nxt();
    smp();
    checks++;
    if (grant !== 4'b0001 || m_tdata !== 8'h40) begin
      errors++;
      $display("FAIL rm_first: got grant=%b data=%h want 0001/40", grant, m_tdata);
    end
    zero_inputs();
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_burst_cap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
